// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcodes, command word, FSM states.
package alu_pkg;

   localparam int unsigned OPW = 4;

   typedef enum logic [2:0] {
      ADD  = 3'b000,
      SUB  = 3'b001,
      AND  = 3'b010,
      OR   = 3'b011,
      XOR  = 3'b100,
      SHL  = 3'b101,
      SHR  = 3'b110,
      RSVD = 3'b111
   } opcode_e;

   typedef struct packed {
      opcode_e        opcode;
      logic [OPW-1:0] a;
      logic [OPW-1:0] b;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      HOLD  = 2'b10
   } state_e;

   function automatic logic is_reserved(input opcode_e op);
      return (op == RSVD);
   endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and result signals of the sequencer; slave is the sequencer's view.
interface alu_cmd_sequencer_if;
   import alu_pkg::*;

   logic           cmd_valid;
   logic           cmd_ready;
   logic [2:0]     cmd_opcode;
   logic [OPW-1:0] cmd_a;
   logic [OPW-1:0] cmd_b;
   logic [OPW-1:0] alu_operand_a;
   logic [OPW-1:0] alu_operand_b;
   logic [2:0]     alu_opcode;
   logic [OPW-1:0] alu_result;
   logic           res_valid;
   logic           res_ready;
   logic [OPW-1:0] res_data;
   logic           res_err;
   logic [7:0]     done_count;

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, res_ready,
      output cmd_ready, alu_operand_a, alu_operand_b, alu_opcode,
             res_valid, res_data, res_err, done_count
   );

   modport master (
      output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, res_ready,
      input  cmd_ready, alu_operand_a, alu_operand_b, alu_opcode,
             res_valid, res_data, res_err, done_count
   );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push_i,
   input  cmd_t        push_data_i,
   input  logic        pop_i,
   output cmd_t        head_o,
   output logic        full_o,
   output logic        empty_o,
   output logic [AW:0] count_o
);

   cmd_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push_s, pop_s;

   assign push_s  = push_i && !full_o;
   assign pop_s   = pop_i && !empty_o;
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // Next pointers and occupancy; a simultaneous push and pop leaves count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is only ever read behind a non-zero count, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues each to an external combinational ALU for one cycle
// and holds the captured result until the consumer takes it.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input logic                clk,
   input logic                rst_n,
   alu_cmd_sequencer_if.slave bus
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_e         state_q, state_d;
   logic [OPW-1:0] res_data_q, res_data_d;
   logic           res_err_q, res_err_d;
   logic [7:0]     done_count_q, done_count_d;

   cmd_t           push_data_s;
   cmd_t           head_s;
   logic           push_s, pop_s, full_s, empty_s;
   logic [CW-1:0]  count_s;
   logic [OPW-1:0] alu_a_s, alu_b_s;
   logic [2:0]     alu_op_s;

   assign push_data_s = '{opcode: opcode_e'(bus.cmd_opcode), a: bus.cmd_a, b: bus.cmd_b};
   assign push_s      = bus.cmd_valid && bus.cmd_ready;

   alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push_s),
      .push_data_i (push_data_s),
      .pop_i       (pop_s),
      .head_o      (head_s),
      .full_o      (full_s),
      .empty_o     (empty_s),
      .count_o     (count_s)
   );

   // Sequencing: ISSUE drives the ALU and captures its answer, HOLD waits for the consumer.
   always_comb begin
      state_d      = state_q;
      res_data_d   = res_data_q;
      res_err_d    = res_err_q;
      done_count_d = done_count_q;
      pop_s        = 1'b0;
      alu_a_s      = '0;
      alu_b_s      = '0;
      alu_op_s     = 3'b000;
      case (state_q)
         IDLE: begin
            if (!empty_s) begin
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            alu_a_s    = head_s.a;
            alu_b_s    = head_s.b;
            alu_op_s   = head_s.opcode;
            res_data_d = bus.alu_result;
            res_err_d  = is_reserved(head_s.opcode);
            pop_s      = 1'b1;
            state_d    = HOLD;
         end
         HOLD: begin
            if (bus.res_ready) begin
               done_count_d = done_count_q + 8'd1;
               // A command arriving on this same edge is enough to go straight back to ISSUE.
               if ((count_s != '0) || push_s) begin
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM, result and handshake counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         res_data_q   <= '0;
         res_err_q    <= 1'b0;
         done_count_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         res_data_q   <= res_data_d;
         res_err_q    <= res_err_d;
         done_count_q <= done_count_d;
      end
   end

   assign bus.cmd_ready     = !full_s;
   assign bus.alu_operand_a = alu_a_s;
   assign bus.alu_operand_b = alu_b_s;
   assign bus.alu_opcode    = alu_op_s;
   assign bus.res_valid     = (state_q == HOLD);
   assign bus.res_data      = res_data_q;
   assign bus.res_err       = res_err_q;
   assign bus.done_count    = done_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed and randomized bench for alu_cmd_sequencer with an external ALU and a
// queue-based scoreboard of expected results.
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
   } stim_t;

   typedef struct {
      logic [3:0] data;
      logic       err;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   exp_done = 0;

   stim_t      stim_q [$];
   exp_t       exp_q  [$];
   logic [3:0] got_q  [$];

   alu_cmd_sequencer_if bus ();

   alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      int r;
      case (op)
         3'd0:    r = int'(a) + int'(b);
         3'd1:    r = int'(a) - int'(b);
         3'd2:    r = int'(a & b);
         3'd3:    r = int'(a | b);
         3'd4:    r = int'(a ^ b);
         3'd5:    r = int'(a) * 2;
         3'd6:    r = int'(a) / 2;
         default: r = 15 - int'(a);
      endcase
      return r[3:0];
   endfunction

   // External combinational ALU
   always_comb bus.alu_result = alu_ref(bus.alu_opcode, bus.alu_operand_a, bus.alu_operand_b);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input stim_t s);
      exp_t e;
      e.data = alu_ref(s.op, s.a, s.b);
      e.err  = (s.op == 3'b111);
      exp_q.push_back(e);
   endtask

   task automatic drive_head();
      if (stim_q.size() > 0) begin
         bus.cmd_opcode = stim_q[0].op;
         bus.cmd_a      = stim_q[0].a;
         bus.cmd_b      = stim_q[0].b;
      end
   endtask

   // Offer commands with res_ready low; returns how many were accepted
   task automatic fill_blocked(input int cycles, output int accepted);
      bit acc;
      accepted = 0;
      bus.res_ready = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         bus.cmd_valid = (stim_q.size() > 0);
         drive_head();
         acc = bus.cmd_valid && bus.cmd_ready;
         if (bus.res_valid && exp_q.size() > 0) chk("held_res_data_stable", bus.res_data, exp_q[0].data);
         tick();
         if (acc) begin
            push_exp(stim_q[0]);
            void'(stim_q.pop_front());
            accepted++;
         end
      end
      bus.cmd_valid = 1'b0;
   endtask

   // Stream stim_q through the DUT and score every handshake
   task automatic run(input bit rand_mode, input int budget);
      int         cyc;
      int         last_hs;
      bit         acc, hs;
      logic [3:0] obs;
      cyc = 0;
      last_hs = -1;
      while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
         bus.cmd_valid = (stim_q.size() > 0) && (!rand_mode || $urandom_range(0, 3) != 0);
         drive_head();
         bus.res_ready = !rand_mode || ($urandom_range(0, 1) == 1);
         acc = bus.cmd_valid && bus.cmd_ready;
         hs  = bus.res_valid && bus.res_ready;
         obs = bus.res_data;
         if (bus.res_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_res_valid", bus.res_valid, 1'b0);
            end else begin
               chk("res_data", bus.res_data, exp_q[0].data);
               chk("res_err", bus.res_err, exp_q[0].err);
            end
         end
         tick();
         if (acc) begin
            push_exp(stim_q[0]);
            void'(stim_q.pop_front());
         end
         if (hs && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            got_q.push_back(obs);
            exp_done++;
            chk("done_count", bus.done_count, exp_done % 256);
            if (!rand_mode && last_hs >= 0) chk("throughput_gap", cyc - last_hs, 2);
            last_hs = cyc;
         end
         cyc++;
      end
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b0;
      chk("run_pending_after_budget", stim_q.size() + exp_q.size(), 0);
      chk("res_valid_after_drain", bus.res_valid, 1'b0);
   endtask

   initial begin
      logic [3:0] seq_exp [7];
      int         accepted;

      seq_exp = '{4'b1101, 4'b0111, 4'b0010, 4'b1011, 4'b1001, 4'b0100, 4'b0101};
      bus.cmd_valid  = 1'b0;
      bus.cmd_opcode = 3'd0;
      bus.cmd_a      = 4'd0;
      bus.cmd_b      = 4'd0;
      bus.res_ready  = 1'b0;

      // Reset state
      #2;
      chk("rst_res_valid", bus.res_valid, 1'b0);
      chk("rst_res_data", bus.res_data, 4'd0);
      chk("rst_res_err", bus.res_err, 1'b0);
      chk("rst_done_count", bus.done_count, 8'd0);
      chk("rst_alu_a", bus.alu_operand_a, 4'd0);
      chk("rst_alu_op", bus.alu_opcode, 3'd0);
      tick();
      tick();
      rst_n = 1'b1;
      chk("rel_cmd_ready", bus.cmd_ready, 1'b1);

      // res_ready with nothing held does nothing
      bus.res_ready = 1'b1;
      tick();
      tick();
      bus.res_ready = 1'b0;
      chk("idle_res_ready_no_effect", bus.done_count, 8'd0);

      // Single add, latency
      bus.cmd_valid = 1'b1; bus.cmd_opcode = 3'b000; bus.cmd_a = 4'b1010; bus.cmd_b = 4'b0011;
      tick();
      bus.cmd_valid = 1'b0;
      chk("lat_n1_res_valid", bus.res_valid, 1'b0);
      tick();
      chk("issue_alu_a", bus.alu_operand_a, 4'b1010);
      chk("issue_alu_b", bus.alu_operand_b, 4'b0011);
      chk("issue_alu_op", bus.alu_opcode, 3'b000);
      chk("lat_issue_res_valid", bus.res_valid, 1'b0);
      tick();
      chk("lat_n2_res_valid", bus.res_valid, 1'b1);
      chk("single_add_data", bus.res_data, 4'b1101);
      chk("single_add_err", bus.res_err, 1'b0);
      chk("hold_alu_a_zero", bus.alu_operand_a, 4'd0);
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      exp_done = 1;
      chk("single_done_count", bus.done_count, 8'd1);
      chk("single_res_valid_drop", bus.res_valid, 1'b0);

      // Seven ops back to back
      got_q.delete();
      for (int i = 0; i < 7; i++) stim_q.push_back('{op: 3'(i), a: 4'b1010, b: 4'b0011});
      run(1'b0, 100);
      chk("seq_count", got_q.size(), 7);
      for (int i = 0; i < 7 && i < got_q.size(); i++) chk($sformatf("seq_result_%0d", i), got_q[i], seq_exp[i]);

      // Backpressure: exactly DEPTH+1 accepted
      for (int i = 0; i < DEPTH + 2; i++)
         stim_q.push_back('{op: 3'($urandom_range(0, 6)), a: 4'($urandom), b: 4'($urandom)});
      fill_blocked(12, accepted);
      chk("bp_accepted", accepted, DEPTH + 1);
      chk("bp_cmd_ready_low", bus.cmd_ready, 1'b0);
      chk("bp_res_valid", bus.res_valid, 1'b1);
      got_q.delete();
      run(1'b0, 100);
      chk("bp_drained", got_q.size(), DEPTH + 2);

      // Reserved opcode then normal op
      stim_q.push_back('{op: 3'b111, a: 4'b0110, b: 4'b0001});
      stim_q.push_back('{op: 3'b010, a: 4'b1100, b: 4'b1010});
      got_q.delete();
      run(1'b0, 50);
      chk("rsvd_result_seen", got_q.size(), 2);

      // Reset while holding with three queued
      for (int i = 0; i < 4; i++)
         stim_q.push_back('{op: 3'($urandom_range(0, 7)), a: 4'($urandom), b: 4'($urandom)});
      fill_blocked(8, accepted);
      chk("rst_mid_accepted", accepted, 4);
      chk("rst_mid_hold", bus.res_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_res_valid", bus.res_valid, 1'b0);
      chk("rst_mid_done_count", bus.done_count, 8'd0);
      chk("rst_mid_res_data", bus.res_data, 4'd0);
      stim_q.delete();
      exp_q.delete();
      exp_done = 0;
      tick();
      rst_n = 1'b1;
      chk("rst_mid_cmd_ready", bus.cmd_ready, 1'b1);
      bus.res_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rst_mid_no_result", bus.res_valid, 1'b0);
      end
      bus.res_ready = 1'b0;
      chk("rst_mid_done_zero", bus.done_count, 8'd0);

      // Random stream of 256 commands; done_count wraps to 0
      for (int i = 0; i < 256; i++)
         stim_q.push_back('{op: 3'($urandom_range(0, 7)), a: 4'($urandom), b: 4'($urandom)});
      run(1'b1, 6000);
      chk("wrap_done_count", bus.done_count, 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  FIFO not full.
REQ-006 SHALL have port cmd_opcode  input  3  ALU opcode.
REQ-007 SHALL have port cmd_a  input  4  operand A.
REQ-008 SHALL have port cmd_b  input  4  operand B.
REQ-009 SHALL have port alu_operand_a  output  4  to combinational ALU.
REQ-010 SHALL have port alu_operand_b  output  4  to combinational ALU.
REQ-011 SHALL have port alu_opcode  output  3  to combinational ALU.
REQ-012 SHALL have port alu_result  input  4  from combinational ALU, same cycle.
REQ-013 SHALL have port res_valid  output  1  result held.
REQ-014 SHALL have port res_ready  input  1  consumer accepts.
REQ-015 SHALL have port res_data  output  4  captured ALU result.
REQ-016 SHALL have port res_err  output  1  result came from reserved opcode 3'b111.
REQ-017 SHALL have port done_count  output  8  completed result handshakes, wraps 255->0.

Function
REQ-018 Opcode map SHALL be 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl-by-1 of A, 110 shr-by-1 of A, 111 reserved.
REQ-019 Command SHALL be written to FIFO on clk edge where cmd_valid && cmd_ready; cmd_ready = (count < DEPTH).
REQ-020 FSM SHALL have states IDLE, ISSUE, HOLD.
REQ-021 IDLE -> ISSUE when FIFO non-empty; else stay.
REQ-022 In ISSUE, alu_* SHALL be driven from FIFO head; at end of the cycle res_data <= alu_result, res_err <= (head opcode == 111), head popped, -> HOLD.
REQ-023 In HOLD, res_valid = 1 and res_data/res_err stable until res_valid && res_ready; then done_count++, -> ISSUE if FIFO non-empty (counting any same-cycle write), else IDLE.
REQ-024 Outside ISSUE, alu_* SHALL be driven to 0.
REQ-025 Latency: command accepted at edge N into empty FIFO, idle FSM -> ISSUE in cycle N+1, res_valid high from edge N+2.
REQ-026 Throughput SHALL be one result per two cycles when res_ready held high.
REQ-027 Simultaneous FIFO write and pop SHALL keep count unchanged, both take effect; write when full SHALL be impossible (cmd_ready low).
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; order SHALL be strict FIFO.
REQ-029 Reserved opcode SHALL still be issued; res_data is whatever alu_result returns; only res_err marks it.
REQ-030 res_ready while res_valid low SHALL have no effect.

Reset
REQ-031 On rst_n low, immediately: FSM IDLE, FIFO empty, pointers 0, res_valid 0, res_data 0, res_err 0, done_count 0, alu_* 0, cmd_ready 1 after release.
REQ-032 Reset mid-operation SHALL discard queued commands and any held result; no res handshake completes in the reset cycle.
REQ-033 Reset deassertion SHALL be synchronised by the integrator; block assumes release away from clk edge.

Structure
REQ-034 Shared package alu_pkg SHALL hold opcode enum (ADD..RSVD), operand width constant 4, command struct {opcode,a,b}, and FSM state enum.
REQ-035 FIFO SHALL be sub-module alu_cmd_fifo (DEPTH param, push/pop/full/empty/count); FSM and result register in top.
REQ-036 The combinational ALU SHALL remain external; bench instantiates it and ties alu_* ports.

Verification
REQ-037 Single add: cmd (000,1010,0011) into idle block -> res_valid at N+2, res_data 1101, res_err 0, done_count 1.
REQ-038 Seven ops back-to-back with res_ready=1, A=1010 B=0011: results 1101,0111,0010,1011,1001,0100,0101 in order, one every 2 cycles.
REQ-039 Backpressure: res_ready=0, push 5 cmds at DEPTH=4 -> cmd_ready low after 4 queued plus 1 held... exactly DEPTH+1 accepted, res_data stable; release -> all drain in order.
REQ-040 Reserved opcode 111 -> res_err 1, done_count increments, following op res_err 0.
REQ-041 Assert rst_n low while in HOLD with 3 queued -> res_valid 0 immediately, after release no results emerge, done_count 0.
REQ-042 256 handshakes -> done_count wraps to 0.
